// File: rtl/mult_div_unit.sv
// Iterative 32-step shift-add multiply / restoring divide with HI/LO result registers.
// Fixed 33-edge latency from accept to result. While busy, start and mthi/mtlo writes are ignored.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               borrow;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy = (state != IDLE);

    always_comb begin
        a_mag     = (op[0] && a[WIDTH-1]) ? -a : a;
        b_mag     = (op[0] && b[WIDTH-1]) ? -b : b;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd};
        borrow    = div_diff[WIDTH];
        prod_fix  = neg_q ? -acc : acc;
        quo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient/dividend} for divide
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
            opnd     <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div   <= op[1];
                        neg_q    <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r    <= op[0] & a[WIDTH-1];
                        div_zero <= (b == '0);
                        a_raw    <= a;
                        opnd     <= op[1] ? b_mag : a_mag;
                        acc      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        count    <= '0;
                        state    <= RUN;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    if (is_div)
                        acc <= {(borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                                acc[WIDTH-2:0], ~borrow};
                    else
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (div_zero) begin
                        hi <= a_raw;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model with a per-cycle compare, plus literal directed cases.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: p = {32'b0, x} * {32'b0, y};
            2'b01: p = sx * sy;
            2'b10: p = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
            default: begin
                if (y == 0) p = {x, 32'hFFFFFFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    // Reference: a countdown of remaining busy cycles and the result computed at accept time
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_pend = '0;
    bit          m_done = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0; m_hi = '0; m_lo = '0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = m_pend[63:32];
                    m_lo = m_pend[31:0];
                    m_done = 1;
                end
            end else if (start) begin
                m_pend = ref_op(op, a, b);
                m_left = 33;
            end else begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", {31'b0, busy}, {31'b0, (m_left > 0)});
            check("model_done", {31'b0, done}, {31'b0, m_done});
            check("model_hi", hi, m_hi);
            check("model_lo", lo, m_lo);
            if (done === 1'b1) done_cnt++;
        end
    end

    // Launch one op, scramble operands after accept, wait for done; returns busy cycle count
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit with_lo_we, output int bcnt, output bit got);
        op = o; a = x; b = y; start = 1'b1; lo_we = with_lo_we; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        start = 1'b0; lo_we = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        bcnt = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
            else if (busy) bcnt++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: no done within 40 cycles (op %0d)", o);
        end
    endtask

    initial begin
        int  bc;
        bit  got;
        int  d0;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);

        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, bc, got);
        check("multu_max_hi", hi, 32'hFFFFFFFE);
        check("multu_max_lo", lo, 32'h00000001);
        check("multu_busy_cycles", bc, 33);
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'h0);

        run_op(2'b01, 32'hFFFFFFFD, 32'h00000005, 0, bc, got);
        check("mult_neg_hi", hi, 32'hFFFFFFFF);
        check("mult_neg_lo", lo, 32'hFFFFFFF1);

        run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 0, bc, got);
        check("div_neg_lo", lo, 32'hFFFFFFFD);
        check("div_neg_hi", hi, 32'hFFFFFFFF);

        run_op(2'b10, 32'h00000064, 32'h0, 0, bc, got);
        check("divu_zero_lo", lo, 32'hFFFFFFFF);
        check("divu_zero_hi", hi, 32'h00000064);
        check("divu_zero_latency", bc, 33);

        // Back-to-back: launch in the done cycle
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0, bc, got);
        check("div_ovf_lo", lo, 32'h80000000);
        check("div_ovf_hi", hi, 32'h0);

        // start while busy is ignored
        @(posedge clk); #1;
        d0 = done_cnt;
        op = 2'b00; a = 3; b = 4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        op = 2'b10; a = 9; b = 3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        repeat (45) @(posedge clk);
        @(negedge clk);
        check("ignore_start_dones", done_cnt - d0, 1);
        check("ignore_start_hi", hi, 32'h0);
        check("ignore_start_lo", lo, 32'h0000000C);

        // reset mid-divide aborts
        @(posedge clk); #1;
        op = 2'b10; a = 100; b = 7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);

        // mthi while idle, then start beating mtlo
        hi_we = 1'b1; wdata = 32'h12345678;
        @(posedge clk); #1 hi_we = 1'b0;
        @(negedge clk);
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_no_done", {31'b0, done}, 32'h0);
        run_op(2'b00, 32'd2, 32'd3, 1, bc, got);
        check("start_wins_lo", lo, 32'h00000006);
        check("start_wins_hi", hi, 32'h0);

        // Random traffic: ops, noise starts/writes while busy, occasional reset
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom);
            case ($urandom_range(0, 3))
                0: a = 32'h80000000;
                1: a = $urandom_range(0, 200);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: b = 32'h0;
                1: b = 32'hFFFFFFFF;
                2: b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            hi_we = ($urandom_range(0, 7) == 0);
            lo_we = ($urandom_range(0, 7) == 0);
            wdata = $urandom;
            reset = ($urandom_range(0, 999) == 0);
        end
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; reset = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
